seg_scan_capture: RTL
=====================

# seg_scan_capture

Receive-side decoder for the multiplexed four-digit seven-segment bus (`sm_wei` / `sm_duan`) that the CPU `top` drives. It watches the scanned digit-enable and segment lines, filters out scan transitions, decodes each glyph back to a hex nibble and reassembles the 16-bit displayed value. It sits in the simulation and loopback harness beside `top`, so benches can check the displayed register or PC value numerically instead of inspecting segment waveforms.

## Interface
- `STABLE_CYC`, default 16: consecutive identical samples required before a digit is committed; legal values are 2..255.
- `TIMEOUT_CYC`, default 1048576: number of cycles without any commit before `stale` asserts; legal values are 2..2^24.
- `clk`  in  1  system clock, same clock that drives `top`.
- `reset`  in  1  synchronous, active-low reset.
- `sm_wei`  in  4  digit enables, active-low; `[3]` is the leftmost (most significant) digit.
- `sm_duan`  in  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `value`  out  16  last complete frame; `[15:12]` comes from digit 3.
- `frame_valid`  out  1  one-cycle pulse when `value` is updated.
- `seg_err`  out  1  one-cycle pulse when a stable glyph is not one of the 16 hex glyphs.
- `wei_err`  out  1  one-cycle pulse when a stable `sm_wei` has more than one bit low.
- `stale`  out  1  level signal: no digit committed for `TIMEOUT_CYC` cycles.

## Operation
- **Input register.** `{sm_wei, sm_duan}` is registered every cycle into `smp`.
- **Dwell counter.** The 8-bit dwell counter clears to 0 whenever `smp` differs from its previous value. Otherwise it increments and saturates at `STABLE_CYC`.
- **Commit.** A commit occurs exactly once per dwell, on the cycle the counter reaches `STABLE_CYC-1`.
- **Commit classification.**
  - `sm_wei` = 4'b1111 (blanking): no action.
  - `sm_wei` has 2 or more bits low: pulse `wei_err`; the glyph is not decoded.
  - `sm_wei` has exactly one bit low (digit d): decode `sm_duan` using the glyph table below.
- **Glyph table (active-low).** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex values).
- **Valid glyph.** Write the nibble into `slot[d]` and set `seen[d]`. A repeat of an already-seen digit overwrites that slot.
- **Invalid glyph.** Pulse `seg_err`. `slot`, `seen` and `value` are not modified.
- **Frame completion.** When a valid commit makes `seen` = 4'b1111, in the same edge:
  - `value` ← `{slot3..slot0}`, including the nibble being committed;
  - `frame_valid` pulses;
  - `seen` clears to 0.
- **Stale detection.** A 24-bit idle counter clears on every valid-glyph commit and otherwise saturates. `stale` = 1 while the counter is ≥ `TIMEOUT_CYC`; it drops the cycle after the next valid commit.
- **Error handling.** Error commits do not clear the idle counter, and they do not clear `seen`.

## Timing
- **Reset (`reset`=0 at an edge).** `value`=0, `frame_valid`=0, `seg_err`=0, `wei_err`=0, `stale`=0. `smp`=7'h7F/4'hF (blank), dwell counter=0, `seen`=0, all slots=0, idle counter=0.
- **Reset mid-operation.** Reset during a partial frame discards it; the first frame after reset requires all four digits again.
- **Latency.** An input pattern first presented before edge E0 produces its commit result, visible after edge E0+`STABLE_CYC`-1, provided the inputs hold through that edge. Therefore `frame_valid` is high during the cycle following that edge.
- **Short dwells.** A dwell shorter than `STABLE_CYC` samples (scan ghosting) produces no commit and no error.
- **Pulse width.** At most one of `frame_valid`, `seg_err`, `wei_err` pulses per cycle, and each pulse lasts exactly 1 cycle.
- **Held pattern.** A pattern held for any length produces exactly one commit.
- **Value holding.** `value` holds between frames.
- **Dwell counter width.** The dwell counter cannot wrap: it saturates at `STABLE_CYC`, so `STABLE_CYC` ≤ 255.
- **Idle counter.** The idle counter saturates at 2^24-1 and never wraps. `stale` does not toggle while the counter is saturated.

## Test plan
- **Reset.** Hold `reset`=0 for 3 cycles with arbitrary inputs → all outputs 0, no pulses.
- **Clean frame.** `STABLE_CYC`=16; scan digits 3,2,1,0 showing "1","2","3","4" (79, 24, 30, 19), 40 cycles each, with 2-cycle blanking between digits → `frame_valid` pulses once, 16 cycles after digit 0 first appears; `value`=16'h1234.
- **Ghosting.** Insert 5-cycle glitch patterns (e.g. `sm_wei`=1101, `sm_duan`=7F) between digits of a "bEEF" frame → no errors, `value`=16'hBEEF.
- **Invalid glyph.** Present digit 1 with `sm_duan`=7'h55 for 20 cycles → a single `seg_err` pulse. Follow with a valid "8" (00) on digit 1 and complete the frame → `value[7:4]`=8.
- **Bad enables.** Present `sm_wei`=4'b0011 for 20 cycles → a single `wei_err` pulse; `seen` unchanged. A later frame still completes correctly.
- **Stale and reset mid-frame.** `TIMEOUT_CYC`=100; hold blank for 120 cycles → `stale`=1 from the 100th idle cycle; then a valid digit commit → `stale`=0 on the next cycle. Separately, assert reset after 2 of 4 digits → no `frame_valid` until 4 new digits have been seen.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: listens to the multiplexed four-digit seven-segment scan
// bus, ignores scan transitions, decodes each glyph back to a hex nibble and
// rebuilds the 16-bit value shown on the display.
module seg_scan_capture #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sm_wei,
    input  logic [6:0]  sm_duan,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        wei_err,
    output logic        stale
);

    localparam logic [7:0]  DWELL_MAX    = 8'(STABLE_CYC);
    localparam logic [7:0]  DWELL_COMMIT = 8'(STABLE_CYC - 2);
    localparam logic [24:0] TIMEOUT_LIM  = 25'(TIMEOUT_CYC);
    localparam logic [23:0] IDLE_MAX     = '1;

    logic [3:0]  smp_wei;
    logic [6:0]  smp_duan;
    logic [7:0]  dwell_cnt;
    logic [3:0]  seen;
    logic [15:0] slots;
    logic [23:0] idle_cnt;

    logic        same_smp;
    logic        commit;
    logic        digit_ok;
    logic        wei_multi;
    logic [1:0]  digit_idx;
    logic        glyph_ok;
    logic [3:0]  nibble;
    logic [3:0]  seen_upd;
    logic [15:0] slots_upd;
    logic        valid_commit;

    // A commit fires on the edge where the dwell counter steps to
    // STABLE_CYC-1, so the sample taken at that edge is the
    // STABLE_CYC-th identical one.
    assign same_smp     = (sm_wei == smp_wei) && (sm_duan == smp_duan);
    assign commit       = same_smp && (dwell_cnt == DWELL_COMMIT);
    assign valid_commit = commit && digit_ok && glyph_ok;
    assign stale        = ({1'b0, idle_cnt} >= TIMEOUT_LIM);

    // Decode the digit enables: exactly one low bit selects a digit.
    always_comb begin
        digit_ok  = 1'b0;
        wei_multi = 1'b0;
        digit_idx = 2'd0;
        case (smp_wei)
            4'b1110: begin digit_ok = 1'b1; digit_idx = 2'd0; end
            4'b1101: begin digit_ok = 1'b1; digit_idx = 2'd1; end
            4'b1011: begin digit_ok = 1'b1; digit_idx = 2'd2; end
            4'b0111: begin digit_ok = 1'b1; digit_idx = 2'd3; end
            4'b1111: ;
            default: wei_multi = 1'b1;
        endcase
    end

    // Map an active-low segment pattern back to its hex nibble.
    always_comb begin
        glyph_ok = 1'b1;
        nibble   = 4'h0;
        case (smp_duan)
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Slot and seen contents as they would look after this digit lands,
    // so a completing frame can publish the nibble in the same edge.
    always_comb begin
        seen_upd  = seen | (4'b0001 << digit_idx);
        slots_upd = slots;
        slots_upd[{digit_idx, 2'b00} +: 4] = nibble;
    end

    // Register the bus and measure how long the sample has been unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            smp_wei   <= 4'hF;
            smp_duan  <= 7'h7F;
            dwell_cnt <= 8'd0;
        end else begin
            smp_wei  <= sm_wei;
            smp_duan <= sm_duan;
            if (!same_smp) begin
                dwell_cnt <= 8'd0;
            end else if (dwell_cnt != DWELL_MAX) begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end

    // Act on a commit: flag bad enables or glyphs, otherwise store the digit
    // and publish the frame once all four digits have been seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value       <= 16'h0000;
            slots       <= 16'h0000;
            seen        <= 4'h0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            wei_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            wei_err     <= 1'b0;
            if (commit) begin
                if (wei_multi) begin
                    wei_err <= 1'b1;
                end else if (digit_ok) begin
                    if (glyph_ok) begin
                        slots <= slots_upd;
                        if (seen_upd == 4'hF) begin
                            value       <= slots_upd;
                            seen        <= 4'h0;
                            frame_valid <= 1'b1;
                        end else begin
                            seen <= seen_upd;
                        end
                    end else begin
                        seg_err <= 1'b1;
                    end
                end
            end
        end
    end

    // Count cycles since the last good digit, saturating instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt <= 24'd0;
        end else if (valid_commit) begin
            idle_cnt <= 24'd0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end

endmodule
